dut_scan_controller: RTL
========================

// Module: dut_scan_controller
// PURPOSE
//  Sequences the combinational device-under-test: applies a host-supplied input vector,
//  walks dut_signal_select over a contiguous range of up to 32 indices, and waits a
//  programmable settle time before sampling dut_output at each index.
//  Packs the sampled bits into one result word returned over a valid/ready handshake.
//  Sits between the host command path and the dut instance; it is the only driver of
//  dut_input and dut_signal_select.
// PARAMETERS
//  SETTLE_CYCLES  4   clocks between a select/input change and its sample; legal range 1..255
//  DATA_WIDTH     32  width of dut_input, dut_signal_select and res_data
// PORTS
//  clk                input   1   the single clock for the block
//  rst_n              input   1   reset: synchronous, active-low
//  cmd_valid          input   1   a scan command is offered
//  cmd_ready          output  1   a command can be accepted; high only in IDLE
//  cmd_input          input   32  vector applied to dut_input for the whole scan
//  cmd_first_sel      input   32  first select index
//  cmd_count          input   6   number of bits to scan, 0..32
//  abort              input   1   stops the current scan; no result is produced
//  busy               output  1   high from the cycle after accept until IDLE is re-entered
//  res_valid          output  1   res_data and res_unstable are valid
//  res_ready          input   1   the host consumes the result
//  res_data           output  32  bit i holds the sample taken at select = first+i
//  res_unstable       output  1   double-sample mismatch seen (see CONFIGURATION)
//  dut_input          output  32  drives the DUT input
//  dut_signal_select  output  32  drives the DUT select
//  dut_output         input   1   sampled DUT bit
// BEHAVIOUR
//  Reset values (rst_n low at a clk edge): state=IDLE, cmd_ready=1, busy=0, res_valid=0,
//   res_data=0, res_unstable=0, dut_input=0, dut_signal_select=0.
//  States: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
//  IDLE: a command is accepted on cmd_valid&&cmd_ready.
//   On accept: latch cmd_input, cmd_first_sel and cmd_count; clear res_data; set idx=0.
//   If count==0, go to DONE with res_data=0. Otherwise go to SETTLE with the settle counter at 0.
//  SETTLE: counts SETTLE_CYCLES clocks, then goes to SAMPLE.
//  SAMPLE (one clock): res_data[idx] <= dut_output and idx++.
//   If idx+1==count, go to DONE.
//   Otherwise dut_signal_select++ (modulo 2^32; wrap is legal) and return to SETTLE.
//  DONE: res_valid=1 and res_data is held stable. Leave to IDLE on res_valid&&res_ready.
//   res_valid drops and cmd_ready rises in the same cycle.
//  Timing: per-bit cost is SETTLE_CYCLES+1 clocks.
//   res_valid rises 1+count*(SETTLE_CYCLES+1) clocks after the accept edge (count>0), or 1 clock when count==0.
//  res_data bits [31:count] are always 0.
//  abort: takes priority in every state except IDLE.
//   Next state is IDLE with cmd_ready=1, busy=0, res_valid=0.
//   dut_input and dut_signal_select hold their last values.
//   abort in IDLE is ignored, and an abort in the same cycle as an accept wins (command is dropped).
//   abort in DONE discards the pending result.
//  cmd_count>32 is clamped to 32.
//  rst_n low mid-scan: same as reset, with no result.
// CONFIGURATION
//  Macro DUT_SCAN_DOUBLE_SAMPLE_EN.
//  Defined: each bit passes SETTLE, SAMPLE, SETTLE, SAMPLE2.
//   SAMPLE2 compares dut_output with the first sample; a mismatch sets res_unstable (sticky for that scan).
//   res_data stores the first sample. Per-bit cost is 2*(SETTLE_CYCLES+1).
//   res_unstable clears on accept.
//  Undefined: no SAMPLE2 state; res_unstable is tied to 0.
// STRUCTURE
//  Package dut_scan_pkg:
//   - state enum {IDLE, SETTLE, SAMPLE, SAMPLE2, DONE}
//   - DATA_WIDTH_DEF=32, COUNT_W=6, MAX_COUNT=32
//  Sub-module dut_settle_timer: loadable down-counter.
//   - inputs: start, clear
//   - output: a one-cycle expired pulse
//   - used for every SETTLE phase
// TESTING
//  Bench DUT model: dut_output = dut_input[dut_signal_select[4:0]]. SETTLE_CYCLES=4 unless noted.
//  1 Full scan: input=32'hA5A5_0F0F, first=0, count=32
//     -> res_data=32'hA5A5_0F0F, res_valid 161 clocks after accept, busy high throughout.
//  2 Partial scan: input=32'hFFFF_0000, first=12, count=8
//     -> res_data=32'h0000_00F0, res_valid at +41, bits [31:8]=0.
//  3 Select wrap: first=32'hFFFF_FFFE, count=4, input=32'h0000_0005
//     -> selects FFFFFFFE, FFFFFFFF, 0, 1 are visited; res_data=32'h4.
//  4 count=0 -> res_valid 1 clock after accept and res_data=0.
//     Hold res_ready low for 10 clocks -> res_data stable, cmd_ready=0.
//  5 abort at the 3rd SAMPLE of a count=32 scan
//     -> next cycle IDLE, cmd_ready=1, no res_valid; a new command is then accepted normally.
//  6 With DUT_SCAN_DOUBLE_SAMPLE_EN: bench toggles dut_output between the two samples of bit 5
//     -> res_unstable=1 and res_valid at 1+count*10.
//     Without the macro, the same stimulus gives res_unstable=0.
//  Also: rst_n low mid-SETTLE -> all outputs at reset values the next clock.

Source files
------------

// File: rtl/dut_scan_pkg.sv
// Shared types and sizing for the DUT scan controller and its settle timer.
// Optional double sampling is selected with DUT_SCAN_DOUBLE_SAMPLE_EN.
package dut_scan_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int COUNT_W        = 6;
  localparam int MAX_COUNT      = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    SAMPLE  = 3'd2,
    SAMPLE2 = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Requests longer than the result word are scanned as a full word.
  function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] count);
    return (count > COUNT_W'(MAX_COUNT)) ? COUNT_W'(MAX_COUNT) : count;
  endfunction

endpackage

// File: rtl/dut_scan_controller_settle_timer.sv
// Loadable down-counter timing each settle phase; expired is high for exactly
// the last cycle of the phase, so the controller can leave SETTLE on that edge.
module dut_settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic expired
);

  logic [7:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt_reg <= 8'd0;
    end else if (start) begin
      cnt_reg <= 8'(SETTLE_CYCLES);
    end else if (cnt_reg != 8'd0) begin
      cnt_reg <= cnt_reg - 8'd1;
    end
  end

  assign expired = (cnt_reg == 8'd1);

endmodule

// File: rtl/dut_scan_controller.sv
// Scans a combinational DUT bit by bit over a select range and returns the packed samples.
// Define DUT_SCAN_DOUBLE_SAMPLE_EN to sample every bit twice and flag unstable outputs.
module dut_scan_controller
  import dut_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_input,
  input  logic [DATA_WIDTH-1:0] cmd_first_sel,
  input  logic [COUNT_W-1:0]    cmd_count,
  input  logic                  abort,
  output logic                  busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_unstable,
  output logic [DATA_WIDTH-1:0] dut_input,
  output logic [DATA_WIDTH-1:0] dut_signal_select,
  input  logic                  dut_output
);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_SETTLE  = SETTLE;
  localparam logic [2:0] S_SAMPLE  = SAMPLE;
  localparam logic [2:0] S_SAMPLE2 = SAMPLE2;
  localparam logic [2:0] S_DONE    = DONE;

  logic [2:0]            state_reg, state_next;
  logic                  cmd_ready_reg, busy_reg, res_valid_reg;
  logic [DATA_WIDTH-1:0] res_data_reg, res_data_next;
  logic [DATA_WIDTH-1:0] input_reg, sel_reg;
  logic [COUNT_W-1:0]    count_reg, idx_reg;
  logic                  first_reg;
  logic                  accept, last;
  logic                  timer_start, timer_clear, timer_expired;
`ifdef DUT_SCAN_DOUBLE_SAMPLE_EN
  logic                  second_reg;
  logic                  first_bit_reg;
  logic                  unstable_reg;
`endif

  assign accept = (state_reg == S_IDLE) && cmd_valid && !abort;
  assign last   = ((idx_reg + COUNT_W'(1)) == count_reg);

  dut_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (timer_start),
    .clear  (timer_clear),
    .expired(timer_expired)
  );

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
    assign res_data_next[gi] = (state_reg == S_SAMPLE && idx_reg == COUNT_W'(gi))
                               ? dut_output : res_data_reg[gi];
  end

  always_comb begin
    state_next  = state_reg;
    timer_start = 1'b0;
    timer_clear = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          timer_clear = 1'b1;
          state_next  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // An empty scan spends this one cycle here so its result appears a clock after accept.
        if (count_reg == '0) begin
          state_next = S_DONE;
        end else begin
          timer_start = first_reg;
`ifdef DUT_SCAN_DOUBLE_SAMPLE_EN
          if (timer_expired) state_next = second_reg ? S_SAMPLE2 : S_SAMPLE;
`else
          if (timer_expired) state_next = S_SAMPLE;
`endif
        end
      end
      S_SAMPLE: begin
`ifdef DUT_SCAN_DOUBLE_SAMPLE_EN
        timer_start = 1'b1;
        state_next  = S_SETTLE;
`else
        if (last) begin
          state_next = S_DONE;
        end else begin
          timer_start = 1'b1;
          state_next  = S_SETTLE;
        end
`endif
      end
      S_SAMPLE2: begin
`ifdef DUT_SCAN_DOUBLE_SAMPLE_EN
        if (last) begin
          state_next = S_DONE;
        end else begin
          timer_start = 1'b1;
          state_next  = S_SETTLE;
        end
`else
        state_next = S_IDLE;
`endif
      end
      S_DONE: begin
        if (res_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (abort && state_reg != S_IDLE) begin
      state_next  = S_IDLE;
      timer_start = 1'b0;
      timer_clear = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      cmd_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      input_reg     <= '0;
      sel_reg       <= '0;
      count_reg     <= '0;
      idx_reg       <= '0;
      first_reg     <= 1'b0;
`ifdef DUT_SCAN_DOUBLE_SAMPLE_EN
      second_reg    <= 1'b0;
      first_bit_reg <= 1'b0;
      unstable_reg  <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cmd_ready_reg <= (state_next == S_IDLE);
      busy_reg      <= (state_next != S_IDLE);
      res_valid_reg <= (state_next == S_DONE);
      if (accept) begin
        input_reg    <= cmd_input;
        sel_reg      <= cmd_first_sel;
        count_reg    <= clamp_count(cmd_count);
        idx_reg      <= '0;
        res_data_reg <= '0;
        first_reg    <= 1'b1;
`ifdef DUT_SCAN_DOUBLE_SAMPLE_EN
        second_reg   <= 1'b0;
        unstable_reg <= 1'b0;
`endif
      end else if (!abort) begin
        case (state_reg)
          S_SETTLE: first_reg <= 1'b0;
          S_SAMPLE: begin
            res_data_reg <= res_data_next;
`ifdef DUT_SCAN_DOUBLE_SAMPLE_EN
            first_bit_reg <= dut_output;
            second_reg    <= 1'b1;
`else
            idx_reg <= idx_reg + COUNT_W'(1);
            if (!last) sel_reg <= sel_reg + DATA_WIDTH'(1);
`endif
          end
`ifdef DUT_SCAN_DOUBLE_SAMPLE_EN
          S_SAMPLE2: begin
            if (dut_output != first_bit_reg) unstable_reg <= 1'b1;
            second_reg <= 1'b0;
            idx_reg    <= idx_reg + COUNT_W'(1);
            if (!last) sel_reg <= sel_reg + DATA_WIDTH'(1);
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign cmd_ready         = cmd_ready_reg;
  assign busy              = busy_reg;
  assign res_valid         = res_valid_reg;
  assign res_data          = res_data_reg;
  assign dut_input         = input_reg;
  assign dut_signal_select = sel_reg;
`ifdef DUT_SCAN_DOUBLE_SAMPLE_EN
  assign res_unstable      = unstable_reg;
`else
  assign res_unstable      = 1'b0;
`endif

endmodule
